// File: rtl/pipe3_pkg.sv
// Shared definitions for the 3-stage ALU pipeline: opcode/funct encodings,
// the internal ALU operation set, and the decoded-instruction record.
package pipe3_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b000011;
    localparam logic [5:0] OP_SUBI  = 6'b000010;
    localparam logic [5:0] OP_XORI  = 6'b000001;
    localparam logic [5:0] OP_ANDI  = 6'b001111;
    localparam logic [5:0] OP_ORI   = 6'b001100;

    localparam logic [5:0] FN_ADD = 6'b000011;
    localparam logic [5:0] FN_SUB = 6'b000010;
    localparam logic [5:0] FN_XOR = 6'b000001;
    localparam logic [5:0] FN_AND = 6'b000111;
    localparam logic [5:0] FN_OR  = 6'b000100;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b001000;
    localparam logic [5:0] FN_SRL = 6'b001001;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_XOR,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_NOP
    } alu_op_e;

    // dest keeps the full 5-bit field; the core trims it to its register address width
    typedef struct packed {
        alu_op_e    alu_op;
        logic [4:0] dest;
        logic       use_imm;
        logic       valid;
        logic       illegal;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ir, input logic ir_valid);
        dec_t d;
        logic known;
        d.alu_op  = ALU_NOP;
        d.dest    = ir[20:16];
        d.use_imm = 1'b1;
        known     = 1'b1;
        case (ir[31:26])
            OP_RTYPE: begin
                d.dest    = ir[15:11];
                d.use_imm = 1'b0;
                case (ir[5:0])
                    FN_ADD:  d.alu_op = ALU_ADD;
                    FN_SUB:  d.alu_op = ALU_SUB;
                    FN_XOR:  d.alu_op = ALU_XOR;
                    FN_AND:  d.alu_op = ALU_AND;
                    FN_OR:   d.alu_op = ALU_OR;
                    FN_SLT:  d.alu_op = ALU_SLT;
                    FN_SLL:  d.alu_op = ALU_SLL;
                    FN_SRL:  d.alu_op = ALU_SRL;
                    default: known    = 1'b0;
                endcase
            end
            OP_ADDI: d.alu_op = ALU_ADD;
            OP_SUBI: d.alu_op = ALU_SUB;
            OP_XORI: d.alu_op = ALU_XOR;
            OP_ANDI: d.alu_op = ALU_AND;
            OP_ORI:  d.alu_op = ALU_OR;
            default: known    = 1'b0;
        endcase
        if (!known) begin
            d.alu_op = ALU_NOP;
        end
        d.valid   = ir_valid;
        d.illegal = ir_valid & ~known;
        return d;
    endfunction

endpackage

// File: rtl/pipe3_regfile.sv
// Register file: two combinational read ports, one clocked write port.
// R0 is a constant zero; all other registers clear on reset.
module pipe3_regfile #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [$clog2(NREG)-1:0] raddr_a,
    output logic [DATA_W-1:0]       rdata_a,
    input  logic [$clog2(NREG)-1:0] raddr_b,
    output logic [DATA_W-1:0]       rdata_b
);
    localparam int REG_AW = $clog2(NREG);

    logic [DATA_W-1:0] rf [NREG];

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign rf[gi] = '0;
            end else begin : g_flop
                logic [DATA_W-1:0] q_reg;
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        q_reg <= '0;
                    end else if (we && waddr == REG_AW'(gi)) begin
                        q_reg <= wdata;
                    end
                end
                assign rf[gi] = q_reg;
            end
        end
    endgenerate

    assign rdata_a = rf[raddr_a];
    assign rdata_b = rf[raddr_b];

endmodule

// File: rtl/pipe3_alu_core.sv
// Three-stage ID/EX/WB integer pipeline: decode and operand fetch with
// EX/WB forwarding, ALU execute, and register-file write-back.
module pipe3_alu_core
    import pipe3_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int FWD_EN = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [31:0]             ibus,
    input  logic                    ibus_valid,
    output logic [DATA_W-1:0]       abus,
    output logic [DATA_W-1:0]       bbus,
    output logic [DATA_W-1:0]       dbus,
    output logic                    dbus_valid,
    output logic [$clog2(NREG)-1:0] wb_addr,
    output logic                    illegal
);
    localparam int REG_AW = $clog2(NREG);

    // ID stage
    logic [31:0]       ir_reg;
    logic              ir_valid_reg;
    dec_t              id_dec;
    logic [REG_AW-1:0] id_rs, id_rt, id_dest;
    logic [DATA_W-1:0] rf_a, rf_b, rs_val, rt_val, imm_sext, op_b;

    // EX stage
    logic [DATA_W-1:0] abus_reg, bbus_reg, alu_out;
    alu_op_e           ex_op_reg;
    logic [REG_AW-1:0] ex_dest_reg;
    logic [4:0]        ex_shamt_reg;
    logic              ex_valid_reg, ex_illegal_reg;

    // WB stage
    logic [DATA_W-1:0] dbus_reg;
    logic              dbus_valid_reg, illegal_reg;
    logic [REG_AW-1:0] wb_addr_reg;

    logic ex_fwd, wb_fwd;

    assign id_dec   = decode(ir_reg, ir_valid_reg);
    assign id_rs    = ir_reg[21 +: REG_AW];
    assign id_rt    = ir_reg[16 +: REG_AW];
    assign id_dest  = id_dec.dest[REG_AW-1:0];
    assign imm_sext = DATA_W'($signed(ir_reg[15:0]));

    pipe3_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (dbus_valid_reg),
        .waddr   (wb_addr_reg),
        .wdata   (dbus_reg),
        .raddr_a (id_rs),
        .rdata_a (rf_a),
        .raddr_b (id_rt),
        .rdata_b (rf_b)
    );

    // Illegal ops and writes to R0 never act as forwarding sources
    assign ex_fwd = ex_valid_reg && !ex_illegal_reg && (ex_dest_reg != '0);
    assign wb_fwd = dbus_valid_reg && (wb_addr_reg != '0);

    always_comb begin
        rs_val = rf_a;
        rt_val = rf_b;
        if (FWD_EN != 0) begin
            if (ex_fwd && ex_dest_reg == id_rs) begin
                rs_val = alu_out;
            end else if (wb_fwd && wb_addr_reg == id_rs) begin
                rs_val = dbus_reg;
            end
            if (ex_fwd && ex_dest_reg == id_rt) begin
                rt_val = alu_out;
            end else if (wb_fwd && wb_addr_reg == id_rt) begin
                rt_val = dbus_reg;
            end
        end
    end

    assign op_b = id_dec.use_imm ? imm_sext : rt_val;

    always_comb begin
        alu_out = '0;
        case (ex_op_reg)
            ALU_ADD: alu_out = abus_reg + bbus_reg;
            ALU_SUB: alu_out = abus_reg - bbus_reg;
            ALU_XOR: alu_out = abus_reg ^ bbus_reg;
            ALU_AND: alu_out = abus_reg & bbus_reg;
            ALU_OR:  alu_out = abus_reg | bbus_reg;
            ALU_SLT: alu_out = ($signed(abus_reg) < $signed(bbus_reg)) ? DATA_W'(1) : '0;
            ALU_SLL: alu_out = abus_reg << ex_shamt_reg;
            ALU_SRL: alu_out = abus_reg >> ex_shamt_reg;
            default: alu_out = '0;
        endcase
    end

    // Bubbles only advance the valid bits; data registers hold their last values
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_reg         <= '0;
            ir_valid_reg   <= 1'b0;
            abus_reg       <= '0;
            bbus_reg       <= '0;
            ex_op_reg      <= ALU_NOP;
            ex_dest_reg    <= '0;
            ex_shamt_reg   <= '0;
            ex_valid_reg   <= 1'b0;
            ex_illegal_reg <= 1'b0;
            dbus_reg       <= '0;
            dbus_valid_reg <= 1'b0;
            illegal_reg    <= 1'b0;
            wb_addr_reg    <= '0;
        end else begin
            ir_reg         <= ibus;
            ir_valid_reg   <= ibus_valid;
            ex_valid_reg   <= id_dec.valid;
            ex_illegal_reg <= id_dec.illegal;
            if (id_dec.valid) begin
                abus_reg     <= rs_val;
                bbus_reg     <= op_b;
                ex_op_reg    <= id_dec.alu_op;
                ex_dest_reg  <= id_dest;
                ex_shamt_reg <= ir_reg[10:6];
            end
            dbus_valid_reg <= ex_valid_reg && !ex_illegal_reg;
            illegal_reg    <= ex_valid_reg && ex_illegal_reg;
            if (ex_valid_reg) begin
                dbus_reg    <= ex_illegal_reg ? '0 : alu_out;
                wb_addr_reg <= ex_dest_reg;
            end
        end
    end

    assign abus       = abus_reg;
    assign bbus       = bbus_reg;
    assign dbus       = dbus_reg;
    assign dbus_valid = dbus_valid_reg;
    assign wb_addr    = wb_addr_reg;
    assign illegal    = illegal_reg;

endmodule

// File: tb/tb_pipe3_alu_core.sv
// Directed bench for pipe3_alu_core: default build, a no-forwarding build and a
// 16-bit/8-register build share one instruction stream.
module tb_pipe3_alu_core;
    import pipe3_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] ibus;
    logic        ibus_valid;

    logic [31:0] abus, bbus, dbus;
    logic        dbus_valid, illegal;
    logic [4:0]  wb_addr;

    logic [31:0] abus_nf, bbus_nf, dbus_nf;
    logic        dbus_valid_nf, illegal_nf;
    logic [4:0]  wb_addr_nf;

    logic [15:0] abus16, bbus16, dbus16;
    logic        dbus_valid16, illegal16;
    logic [2:0]  wb_addr16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe3_alu_core #(.DATA_W(32), .NREG(32), .FWD_EN(1)) dut (
        .clk(clk), .reset_n(reset_n), .ibus(ibus), .ibus_valid(ibus_valid),
        .abus(abus), .bbus(bbus), .dbus(dbus), .dbus_valid(dbus_valid),
        .wb_addr(wb_addr), .illegal(illegal)
    );

    pipe3_alu_core #(.DATA_W(32), .NREG(32), .FWD_EN(0)) dut_nf (
        .clk(clk), .reset_n(reset_n), .ibus(ibus), .ibus_valid(ibus_valid),
        .abus(abus_nf), .bbus(bbus_nf), .dbus(dbus_nf), .dbus_valid(dbus_valid_nf),
        .wb_addr(wb_addr_nf), .illegal(illegal_nf)
    );

    pipe3_alu_core #(.DATA_W(16), .NREG(8), .FWD_EN(1)) dut16 (
        .clk(clk), .reset_n(reset_n), .ibus(ibus), .ibus_valid(ibus_valid),
        .abus(abus16), .bbus(bbus16), .dbus(dbus16), .dbus_valid(dbus_valid16),
        .wb_addr(wb_addr16), .illegal(illegal16)
    );

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge; the next rising edge captures the instruction
    task automatic drive(input logic [31:0] ins, input logic v);
        @(negedge clk);
        ibus       = ins;
        ibus_valid = v;
    endtask

    initial begin
        reset_n    = 1'b0;
        ibus       = '0;
        ibus_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_abus", abus, 32'h0);
        chk("rst_bbus", bbus, 32'h0);
        chk("rst_dbus", dbus, 32'h0);
        chk("rst_dbus_valid", 32'(dbus_valid), 32'h0);
        chk("rst_wb_addr", 32'(wb_addr), 32'h0);
        chk("rst_illegal", 32'(illegal), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset mid-stream: two instructions in flight are discarded
        drive(itype(OP_ADDI, 5'd0, 5'd2, 16'h0055), 1'b1);
        drive(itype(OP_ADDI, 5'd0, 5'd11, 16'h0066), 1'b1);
        drive(32'h0, 1'b0);
        chk("prerst_bbus", bbus, 32'h00000055);
        reset_n = 1'b0;
        #1;
        chk("async_rst_bbus", bbus, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // T1: write to R0 shows on dbus but R0 stays zero
        drive(itype(OP_ADDI, 5'd0, 5'd0, 16'hFFFF), 1'b1);
        drive(itype(OP_ADDI, 5'd0, 5'd2, 16'h0001), 1'b1);
        drive(rtype(5'd11, 5'd0, 5'd12, 5'd0, FN_ADD), 1'b1);
        chk("t1_r0_bbus", bbus, 32'hFFFFFFFF);
        drive(32'h0, 1'b0);
        chk("t1_r0_dbus", dbus, 32'hFFFFFFFF);
        chk("t1_r0_dbus_valid", 32'(dbus_valid), 32'h1);
        chk("t1_r2_abus", abus, 32'h0);
        drive(32'h0, 1'b0);
        chk("t1_r11_discarded", abus, 32'h0);
        chk("t1_r2_dbus", dbus, 32'h00000001);
        chk("t1_r2_wb_addr", 32'(wb_addr), 32'h2);

        // T2: back-to-back dependency via EX forwarding
        drive(itype(OP_ORI, 5'd1, 5'd3, 16'h7334), 1'b1);
        drive(rtype(5'd3, 5'd3, 5'd4, 5'd0, FN_ADD), 1'b1);
        drive(32'h0, 1'b0);
        drive(32'h0, 1'b0);
        chk("t2_ex_fwd_abus", abus, 32'h00007334);
        chk("t2_ex_fwd_bbus", bbus, 32'h00007334);
        chk("t2_ori_dbus", dbus, 32'h00007334);
        drive(32'h0, 1'b0);
        chk("t2_add_dbus", dbus, 32'h0000E668);
        chk("t2_bubble_abus_hold", abus, 32'h00007334);
        drive(32'h0, 1'b0);
        chk("t2_bubble_dbus_hold", dbus, 32'h0000E668);
        chk("t2_bubble_dbus_valid", 32'(dbus_valid), 32'h0);

        // T3: WB forwarding across one bubble; no-forward build reads stale zero
        drive(itype(OP_ORI, 5'd0, 5'd5, 16'hF98B), 1'b1);
        drive(32'h0, 1'b0);
        drive(itype(OP_SUBI, 5'd5, 5'd6, 16'h0030), 1'b1);
        drive(32'h0, 1'b0);
        drive(32'h0, 1'b0);
        chk("t3_wb_fwd_abus", abus, 32'hFFFFF98B);
        chk("t3_imm_bbus", bbus, 32'h00000030);
        chk("t3_nofwd_abus", abus_nf, 32'h0);
        drive(32'h0, 1'b0);
        chk("t3_subi_dbus", dbus, 32'hFFFFF95B);
        chk("t3_nofwd_dbus", dbus_nf, 32'hFFFFFFD0);

        // T4: shifts and signed compare
        drive(itype(OP_ORI, 5'd0, 5'd7, 16'h0001), 1'b1);
        drive(rtype(5'd7, 5'd0, 5'd8, 5'd31, FN_SLL), 1'b1);
        drive(rtype(5'd8, 5'd0, 5'd9, 5'd4, FN_SRL), 1'b1);
        drive(rtype(5'd8, 5'd7, 5'd10, 5'd0, FN_SLT), 1'b1);
        drive(32'h0, 1'b0);
        chk("t4_sll_dbus", dbus, 32'h80000000);
        drive(32'h0, 1'b0);
        chk("t4_srl_dbus", dbus, 32'h08000000);
        chk("t4_slt_abus", abus, 32'h80000000);
        chk("t4_slt_bbus", bbus, 32'h00000001);
        drive(32'h0, 1'b0);
        chk("t4_slt_dbus", dbus, 32'h00000001);

        // T5: illegal opcode between two legal instructions
        drive(itype(OP_ADDI, 5'd0, 5'd1, 16'h0010), 1'b1);
        drive(itype(6'b111111, 5'd0, 5'd1, 16'h1234), 1'b1);
        drive(itype(OP_ADDI, 5'd0, 5'd13, 16'h0020), 1'b1);
        drive(32'h0, 1'b0);
        chk("t5_pre_dbus", dbus, 32'h00000010);
        chk("t5_pre_illegal", 32'(illegal), 32'h0);
        drive(32'h0, 1'b0);
        chk("t5_ill_pulse", 32'(illegal), 32'h1);
        chk("t5_ill_dbus_valid", 32'(dbus_valid), 32'h0);
        chk("t5_ill_dbus", dbus, 32'h0);
        drive(rtype(5'd1, 5'd13, 5'd14, 5'd0, FN_ADD), 1'b1);
        chk("t5_post_dbus", dbus, 32'h00000020);
        chk("t5_post_illegal", 32'(illegal), 32'h0);
        drive(32'h0, 1'b0);
        drive(32'h0, 1'b0);
        chk("t5_r1_committed", abus, 32'h00000010);
        chk("t5_r13_committed", bbus, 32'h00000020);
        drive(32'h0, 1'b0);
        chk("t5_add_dbus", dbus, 32'h00000030);

        // T6: 16-bit build wraps on overflow
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        drive(itype(OP_ADDI, 5'd0, 5'd1, 16'h8000), 1'b1);
        drive(rtype(5'd1, 5'd1, 5'd2, 5'd0, FN_ADD), 1'b1);
        drive(32'h0, 1'b0);
        drive(32'h0, 1'b0);
        chk("t6_w16_addi_dbus", 32'(dbus16), 32'h00008000);
        chk("t6_w32_addi_dbus", dbus, 32'hFFFF8000);
        drive(32'h0, 1'b0);
        chk("t6_w16_add_wrap", 32'(dbus16), 32'h00000000);
        chk("t6_w16_wb_addr", 32'(wb_addr16), 32'h2);
        chk("t6_w32_add_dbus", dbus, 32'hFFFF0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
